imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, word-address width of the instruction-memory write port; depth is 2^ADDR_WIDTH words.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to begin a load.
REQ-005 in_valid  input  1  byte-stream valid.
REQ-006 in_data  input  8  byte-stream data, little-endian within each 32-bit instruction.
REQ-007 in_last  input  1  marks final byte of the program, qualified by in_valid.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 wr_en  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 wr_addr  output  ADDR_WIDTH  word address for the write.
REQ-011 wr_data  output  32  assembled instruction word.
REQ-012 core_rst  output  1  active-high reset held on the single-cycle core while it must not fetch.
REQ-013 done  output  1  load finished; level until next start or rst.
REQ-014 error  output  1  load ended abnormally (partial word or overflow); level until next start or rst.
REQ-015 word_count  output  ADDR_WIDTH+1  number of words written in the current or last load.

Function
REQ-016 FSM states: IDLE, LOAD, WRITE, DONE.
REQ-017 Byte handshake occurs on a cycle with in_valid=1 and in_ready=1; in_ready=1 only in LOAD.
REQ-018 IDLE: start -> LOAD, clearing byte lane counter, wr_addr, word_count, done, error.
REQ-019 LOAD: accepted byte written to lane byte_cnt (lane 0 = bits 7:0, ... lane 3 = bits 31:24); byte_cnt increments mod 4.
REQ-020 LOAD: handshake on lane 3, or handshake with in_last on any lane -> WRITE.
REQ-021 in_last on lane 0-2: unfilled upper lanes written as 0x00, error set to 1.
REQ-022 WRITE: wr_en=1 for exactly one cycle, wr_addr = current word address, wr_data = assembled word; write occurs the cycle after the completing handshake (latency 1).
REQ-023 WRITE: word_count increments; wr_addr increments after the write, except it does not wrap.
REQ-024 WRITE -> DONE if the word carried in_last; WRITE -> DONE with error=1 if the address just written was 2^ADDR_WIDTH-1 and in_last not yet seen (overflow); otherwise WRITE -> LOAD.
REQ-025 Overflow: no byte accepted after the final address is written; no further wr_en.
REQ-026 DONE: done=1, core_rst=0; start -> LOAD with core_rst=1, done=0, error=0, counters cleared.
REQ-027 start in LOAD or WRITE is ignored.
REQ-028 wr_en=0 in every state except WRITE; wr_addr/wr_data hold their last values when wr_en=0.
REQ-029 core_rst=1 in IDLE, LOAD and WRITE; 0 only in DONE.
REQ-030 in_data is ignored when no handshake occurs; in_last is ignored without in_valid.

Reset
REQ-031 rst=1 forces immediately, without clock: state=IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, core_rst=1, done=0, error=0, word_count=0, byte_cnt=0.
REQ-032 rst asserted mid-load aborts the load; no write of a partially assembled word occurs; after release the block waits in IDLE for start.

Verification
REQ-033 After rst, start, bytes 93 00 50 00 13 01 A0 00 (last on final) -> wr_en at addr 0 data 0x00500093, at addr 1 data 0x00A00113, done=1, error=0, word_count=2, core_rst falls the cycle DONE is entered.
REQ-034 Bytes 93 00 50 with in_last on third -> one write, addr 0 data 0x00500093, error=1, done=1.
REQ-035 ADDR_WIDTH=2, 20 bytes without in_last -> writes to addr 0..3 only, error=1, in_ready=0 afterwards, word_count=4.
REQ-036 in_valid toggled with gaps and start pulsed during LOAD -> same words and addresses as gap-free case; start has no effect.
REQ-037 rst asserted between bytes 2 and 3 of a word -> all outputs at reset values within the same cycle, no wr_en; new start reloads from addr 0.
REQ-038 Second start after DONE -> core_rst=1, done=0, error=0, word_count=0, reload begins at addr 0.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: assembles a little-endian byte stream into
// 32-bit words, writes them to sequential addresses and holds the core in reset until done.
module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  core_rst,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);

    state_t                r_state;
    logic [1:0]            r_byte_cnt;
    logic [31:0]           r_word;
    logic [31:0]           r_wr_data;
    logic [ADDR_WIDTH-1:0] r_next_addr;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ADDR_WIDTH:0]   r_word_count;
    logic                  r_last;
    logic                  r_error;

    logic                  w_hs;
    logic                  w_complete;
    logic [31:0]           w_word;

    assign w_hs       = in_valid && (r_state == S_LOAD);
    assign w_complete = w_hs && ((r_byte_cnt == 2'd3) || in_last);

    // Current word with the incoming byte merged in; a short final word gets zero upper lanes.
    always_comb begin
        // NOTE: default assignment first so no path through the loop can infer a latch.
        w_word = r_word;
        for (int i = 0; i < 4; i++) begin
            if (2'(i) == r_byte_cnt) begin
                w_word[8*i +: 8] = in_data;
            end else if ((2'(i) > r_byte_cnt) && in_last) begin
                w_word[8*i +: 8] = 8'h00;
            end
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_byte_cnt   <= 2'd0;
            r_word       <= 32'h0;
            r_wr_data    <= 32'h0;
            r_next_addr  <= '0;
            r_wr_addr    <= '0;
            r_word_count <= '0;
            r_last       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state      <= S_LOAD;
                        r_byte_cnt   <= 2'd0;
                        r_next_addr  <= '0;
                        r_wr_addr    <= '0;
                        r_word_count <= '0;
                        r_last       <= 1'b0;
                        r_error      <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_hs) begin
                        r_word     <= w_word;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                    if (w_complete) begin
                        r_state   <= S_WRITE;
                        r_wr_data <= w_word;
                        r_wr_addr <= r_next_addr;
                        r_last    <= in_last;
                        if (in_last && (r_byte_cnt != 2'd3)) begin
                            r_error <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    r_word_count <= r_word_count + CNT_ONE;
                    if (r_last) begin
                        r_state <= S_DONE;
                    end else if (r_next_addr == LAST_ADDR) begin
                        // Memory full before the program ended: stop without wrapping.
                        r_state <= S_DONE;
                        r_error <= 1'b1;
                    end else begin
                        r_state     <= S_LOAD;
                        r_next_addr <= r_next_addr + ADDR_ONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == S_LOAD);
    assign wr_en      = (r_state == S_WRITE);
    assign core_rst   = (r_state != S_DONE);
    assign done       = (r_state == S_DONE);
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign error      = r_error;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: one default-depth and one 4-word instance share the byte stream;
// each load is compared against a word-list model built from the byte list.
module tb_imem_loader;

    localparam int AW_B = 10;
    localparam int AW_S = 2;

    logic clk = 1'b0;
    logic rst, start_b, start_s, in_valid, in_last;
    logic [7:0] in_data;

    logic            in_ready_b, wr_en_b, core_rst_b, done_b, error_b;
    logic [AW_B-1:0] wr_addr_b;
    logic [31:0]     wr_data_b;
    logic [AW_B:0]   word_count_b;

    logic            in_ready_s, wr_en_s, core_rst_s, done_s, error_s;
    logic [AW_S-1:0] wr_addr_s;
    logic [31:0]     wr_data_s;
    logic [AW_S:0]   word_count_s;

    int total = 0;
    int bad   = 0;
    int phase_bad = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t wq_b[$];
    wr_t wq_s[$];

    imem_loader #(.ADDR_WIDTH(AW_B)) u_big (
        .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .core_rst(core_rst_b), .done(done_b), .error(error_b),
        .word_count(word_count_b)
    );

    imem_loader #(.ADDR_WIDTH(AW_S)) u_small (
        .clk(clk), .rst(rst), .start(start_s), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready_s), .wr_en(wr_en_s), .wr_addr(wr_addr_s),
        .wr_data(wr_data_s), .core_rst(core_rst_s), .done(done_s), .error(error_s),
        .word_count(word_count_s)
    );

    always #5 clk = ~clk;

    // Capture every write strobe and watch that core reset and done are always complementary.
    always @(negedge clk) begin
        if (wr_en_b === 1'b1) wq_b.push_back('{int'(wr_addr_b), wr_data_b});
        if (wr_en_s === 1'b1) wq_s.push_back('{int'(wr_addr_s), wr_data_s});
        if (core_rst_b === done_b) phase_bad++;
        if (core_rst_s === done_s) phase_bad++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sel_done(input int sel);
        return (sel == 0) ? done_b : done_s;
    endfunction

    function automatic logic sel_ready(input int sel);
        return (sel == 0) ? in_ready_b : in_ready_s;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, ".in_ready"}, 64'(in_ready_b), 64'd0);
        check({tag, ".wr_en"}, 64'(wr_en_b), 64'd0);
        check({tag, ".wr_addr"}, 64'(wr_addr_b), 64'd0);
        check({tag, ".wr_data"}, 64'(wr_data_b), 64'd0);
        check({tag, ".core_rst"}, 64'(core_rst_b), 64'd1);
        check({tag, ".done"}, 64'(done_b), 64'd0);
        check({tag, ".error"}, 64'(error_b), 64'd0);
        check({tag, ".word_count"}, 64'(word_count_b), 64'd0);
    endtask

    task automatic pulse_start(input int sel);
        @(negedge clk);
        if (sel == 0) start_b = 1'b1; else start_s = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        start_s = 1'b0;
    endtask

    // Stream the bytes with optional idle gaps, junk data and stray start pulses during gaps.
    task automatic run_load(input string tag, input int sel, input logic [7:0] b[$],
                            input bit with_last, input bit gappy);
        int idx = 0;
        int cyc = 0;
        bit hs;
        pulse_start(sel);
        if (sel == 0) begin
            check({tag, ".start.core_rst"}, 64'(core_rst_b), 64'd1);
            check({tag, ".start.done"}, 64'(done_b), 64'd0);
            check({tag, ".start.error"}, 64'(error_b), 64'd0);
            check({tag, ".start.word_count"}, 64'(word_count_b), 64'd0);
            check({tag, ".start.wr_addr"}, 64'(wr_addr_b), 64'd0);
        end else begin
            check({tag, ".start.core_rst"}, 64'(core_rst_s), 64'd1);
            check({tag, ".start.done"}, 64'(done_s), 64'd0);
            check({tag, ".start.error"}, 64'(error_s), 64'd0);
            check({tag, ".start.word_count"}, 64'(word_count_s), 64'd0);
        end
        while (idx < b.size() && cyc < 4000 && !sel_done(sel)) begin
            if (gappy && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
                if (sel == 0) start_b = 1'($urandom); else start_s = 1'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = b[idx];
                in_last  = with_last && (idx == b.size() - 1);
            end
            hs = in_valid && sel_ready(sel);
            @(negedge clk);
            start_b = 1'b0;
            start_s = 1'b0;
            if (hs) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        while (!sel_done(sel) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, ".reached_done"}, 64'(sel_done(sel)), 64'd1);
    endtask

    // Reference: chop bytes into little-endian words, pad the tail with zeros, cap at memory depth.
    task automatic check_load(input string tag, input int sel, input logic [7:0] b[$],
                              input bit with_last);
        wr_t q[$];
        int depth = (sel == 0) ? (1 << AW_B) : (1 << AW_S);
        int n = b.size();
        int nw = (n + 3) / 4;
        bit overflow = !(with_last && n <= 4 * depth);
        int nwr = overflow ? depth : nw;
        bit err = overflow || (n % 4 != 0);
        logic [31:0] w;
        if (sel == 0) begin
            q = wq_b;
            wq_b.delete();
        end else begin
            q = wq_s;
            wq_s.delete();
        end
        check({tag, ".num_writes"}, 64'(q.size()), 64'(nwr));
        for (int i = 0; i < q.size() && i < nwr; i++) begin
            for (int j = 0; j < 4; j++) begin
                w[8*j +: 8] = (4 * i + j < n) ? b[4 * i + j] : 8'h00;
            end
            check($sformatf("%s.addr[%0d]", tag, i), 64'(q[i].addr), 64'(i));
            check($sformatf("%s.data[%0d]", tag, i), 64'(q[i].data), 64'(w));
        end
        if (sel == 0) begin
            check({tag, ".done"}, 64'(done_b), 64'd1);
            check({tag, ".error"}, 64'(error_b), 64'(err));
            check({tag, ".word_count"}, 64'(word_count_b), 64'(nwr));
            check({tag, ".core_rst"}, 64'(core_rst_b), 64'd0);
            check({tag, ".in_ready"}, 64'(in_ready_b), 64'd0);
        end else begin
            check({tag, ".done"}, 64'(done_s), 64'd1);
            check({tag, ".error"}, 64'(error_s), 64'(err));
            check({tag, ".word_count"}, 64'(word_count_s), 64'(nwr));
            check({tag, ".core_rst"}, 64'(core_rst_s), 64'd0);
            check({tag, ".in_ready"}, 64'(in_ready_s), 64'd0);
        end
    endtask

    initial begin
        logic [7:0] prog[$];
        logic [7:0] rnd[$];
        int sel, n;
        bit wl;

        rst = 1'b1; start_b = 1'b0; start_s = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        #1;
        check_reset_outputs("por");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Two-instruction program, gap-free.
        prog = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
        run_load("basic", 0, prog, 1'b1, 1'b0);
        check_load("basic", 0, prog, 1'b1);

        // Program ending mid-word, started again straight from DONE.
        prog = '{8'h93, 8'h00, 8'h50};
        run_load("partial", 0, prog, 1'b1, 1'b0);
        check_load("partial", 0, prog, 1'b1);

        // 20 bytes into a 4-word memory with no end marker.
        rnd.delete();
        for (int i = 0; i < 20; i++) rnd.push_back(8'($urandom));
        run_load("overflow", 1, rnd, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_load("overflow", 1, rnd, 1'b0);

        // Same two-instruction program with gaps, junk and stray starts.
        prog = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
        run_load("gappy", 0, prog, 1'b1, 1'b1);
        check_load("gappy", 0, prog, 1'b1);

        // Reset between the second and third byte of a word.
        pulse_start(0);
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = 8'hC0 + 8'(k);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst.no_write", 64'(wq_b.size()), 64'd0);
        check("midrst.idle_wait", 64'(in_ready_b), 64'd0);
        wq_s.delete();
        run_load("after_rst", 0, prog, 1'b1, 1'b0);
        check_load("after_rst", 0, prog, 1'b1);

        // Random programs on both depths.
        for (int t = 0; t < 8; t++) begin
            sel = int'($urandom_range(0, 1));
            n   = int'($urandom_range(1, (sel == 0) ? 40 : 24));
            wl  = (sel == 0) ? 1'b1 : ((n >= 16) ? 1'($urandom) : 1'b1);
            rnd.delete();
            for (int i = 0; i < n; i++) rnd.push_back(8'($urandom));
            run_load($sformatf("rand%0d", t), sel, rnd, wl, 1'($urandom));
            repeat (2) @(negedge clk);
            check_load($sformatf("rand%0d", t), sel, rnd, wl);
        end

        check("core_rst_vs_done", 64'(phase_bad), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
